// File: rtl/packet_wb_arbiter.sv
// packet_wb_arbiter
//   Arbitrates the single write path into the packet SRAM. The dispatch source
//   has strict priority, and the NUM_REQ Edge PE requesters share the path
//   round-robin. Each accepted packet lands in one output register. After
//   MAX_BURST back-to-back consumptions a one-cycle SLOT state is inserted so
//   the controller gets an SRAM read opportunity.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             synchronous clear, same effect as reset
//   dp_valid/_packet  dispatch request and packet; dp_ready accepts it
//   req_valid/_packet Edge PE requests; requester i at [i*PKT_W +: PKT_W]
//   req_ready         one-hot accept for the Edge PEs
//   wb_valid/_packet  registered packet to the controller
//   wb_src            source index (NUM_REQ = dispatch)
//   wb_ready          controller consumes wb_* this cycle
//   read_slot         one-cycle pulse: controller may issue an SRAM read
//   busy              anything pending, held or in flight
module packet_wb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PKT_W     = 64,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       dp_valid,
  input  logic [PKT_W-1:0]           dp_packet,
  output logic                       dp_ready,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*PKT_W-1:0]   req_packet,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       wb_valid,
  output logic [PKT_W-1:0]           wb_packet,
  output logic [$clog2(NUM_REQ+1)-1:0] wb_src,
  input  logic                       wb_ready,
  output logic                       read_slot,
  output logic                       busy
);

  localparam int SRC_W = $clog2(NUM_REQ + 1);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {RUN, SLOT} state_t;

  state_t             state_q, state_d;
  logic               wb_valid_q, wb_valid_d;
  logic [PKT_W-1:0]   wb_packet_q, wb_packet_d;
  logic [SRC_W-1:0]   wb_src_q, wb_src_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic               clr;
  logic               consume;
  logic               burst_hit;
  logic               load_en;
  logic               dp_grant;
  logic               pe_grant;
  logic               pe_found;
  logic [PTR_W-1:0]   pe_idx;
  logic [PKT_W-1:0]   req_pkt_arr [NUM_REQ];

  assign clr     = reset | flush;
  assign consume = wb_valid_q & wb_ready;
  // The MAX_BURST-th consumption closes the burst; no new load that cycle so
  // the output register is empty while the controller reads.
  assign burst_hit = consume && (burst_cnt_q == CNT_W'(MAX_BURST - 1));
  // clr is folded in so no handshake completes while reset/flush is high.
  assign load_en = (state_q == RUN) && (!wb_valid_q || wb_ready) && !burst_hit && !clr;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_pkt_arr[gi] = req_packet[gi*PKT_W +: PKT_W];
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ. The sum
  // is one bit wider so non-power-of-two NUM_REQ wraps correctly.
  always_comb begin
    logic [PTR_W:0] sum;
    pe_found = 1'b0;
    pe_idx   = '0;
    sum      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!pe_found && req_valid[sum[PTR_W-1:0]]) begin
        pe_found = 1'b1;
        pe_idx   = sum[PTR_W-1:0];
      end
    end
  end

  assign dp_grant = load_en & dp_valid;
  assign pe_grant = load_en & !dp_valid & pe_found;
  assign dp_ready = dp_grant;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = pe_grant && (pe_idx == PTR_W'(gi));
  end

  always_comb begin
    state_d     = state_q;
    wb_valid_d  = wb_valid_q;
    wb_packet_d = wb_packet_q;
    wb_src_d    = wb_src_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;

    if (state_q == SLOT) begin
      state_d = RUN;
    end

    // A RUN cycle with an empty output register is a natural read gap, so the
    // burst count restarts there.
    if (burst_hit) begin
      burst_cnt_d = '0;
      state_d     = SLOT;
    end else if (consume) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end else if ((state_q == RUN) && !wb_valid_q) begin
      burst_cnt_d = '0;
    end

    if (dp_grant) begin
      wb_valid_d  = 1'b1;
      wb_packet_d = dp_packet;
      wb_src_d    = SRC_W'(NUM_REQ);
    end else if (pe_grant) begin
      wb_valid_d  = 1'b1;
      wb_packet_d = req_pkt_arr[pe_idx];
      wb_src_d    = SRC_W'(pe_idx);
      rr_ptr_d    = (pe_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pe_idx + PTR_W'(1);
    end else if (consume) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= RUN;
      wb_valid_q  <= 1'b0;
      wb_packet_q <= '0;
      wb_src_q    <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_packet_q <= wb_packet_d;
      wb_src_q    <= wb_src_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_packet = wb_packet_q;
  assign wb_src    = wb_src_q;
  assign read_slot = (state_q == SLOT) && !clr;
  assign busy      = wb_valid_q | dp_valid | (|req_valid);

endmodule

// File: tb/tb_packet_wb_arbiter.sv
// Directed testbench for packet_wb_arbiter (NUM_REQ=4, PKT_W=64, MAX_BURST=4).
// Each step drives one cycle of inputs and checks the outputs against
// hand-computed expectations; one line is printed per step.
module tb_packet_wb_arbiter;

  localparam int NR = 4;
  localparam int PW = 64;

  logic            clk = 1'b0;
  logic            reset, flush;
  logic            dp_valid;
  logic [PW-1:0]   dp_packet;
  logic            dp_ready;
  logic [NR-1:0]   req_valid;
  logic [NR*PW-1:0] req_packet;
  logic [NR-1:0]   req_ready;
  logic            wb_valid;
  logic [PW-1:0]   wb_packet;
  logic [2:0]      wb_src;
  logic            wb_ready;
  logic            read_slot;
  logic            busy;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] dp_pkt_exp = '0;

  packet_wb_arbiter #(.NUM_REQ(NR), .PKT_W(PW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .dp_valid   (dp_valid),
    .dp_packet  (dp_packet),
    .dp_ready   (dp_ready),
    .req_valid  (req_valid),
    .req_packet (req_packet),
    .req_ready  (req_ready),
    .wb_valid   (wb_valid),
    .wb_packet  (wb_packet),
    .wb_src     (wb_src),
    .wb_ready   (wb_ready),
    .read_slot  (read_slot),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pe_pkt(input int i);
    return 64'hBEEF_0000_0000_0000 | 64'(i);
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the clock edge, outputs are checked 2
  // units later, then the step waits for the next edge.
  task automatic step(input string tag, input logic rst, input logic fl,
                      input logic dpv, input logic [PW-1:0] dpk,
                      input logic [NR-1:0] rqv, input logic wbr,
                      input logic exp_dpr, input logic [NR-1:0] exp_rqr,
                      input logic exp_wv, input int exp_src, input logic exp_rs);
    reset     = rst;
    flush     = fl;
    dp_valid  = dpv;
    dp_packet = dpk;
    req_valid = rqv;
    wb_ready  = wbr;
    #2;
    chk({tag, ".dp_ready"},  64'(dp_ready),  64'(exp_dpr));
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(exp_rqr));
    chk({tag, ".onehot"},    64'($countones(req_ready) <= 1), 64'(1));
    chk({tag, ".wb_valid"},  64'(wb_valid),  64'(exp_wv));
    chk({tag, ".read_slot"}, 64'(read_slot), 64'(exp_rs));
    chk({tag, ".busy"},      64'(busy),      64'(exp_wv | dpv | (|rqv)));
    if (exp_wv) begin
      chk({tag, ".wb_src"},    64'(wb_src), 64'(exp_src));
      chk({tag, ".wb_packet"}, wb_packet, (exp_src == NR) ? dp_pkt_exp : pe_pkt(exp_src));
    end
    $display("step %s: dp_ready=%0b req_ready=%b wb_valid=%0b wb_src=%0d read_slot=%0b",
             tag, dp_ready, req_ready, wb_valid, wb_src, read_slot);
    if (exp_dpr) dp_pkt_exp = dpk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) req_packet[i*PW +: PW] = pe_pkt(i);
    reset = 1'b1; flush = 1'b0; dp_valid = 1'b1; dp_packet = 64'hDA;
    req_valid = 4'b1111; wb_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held for a second cycle with every request active.
    step("rst",  1, 0, 1, 64'hDA, 4'b1111, 1, 0, 4'b0000, 0, 0, 0);

    // Round robin with burst-forced read slots.
    step("rr0",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0001, 0, 0, 0);
    step("rr1",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0010, 1, 0, 0);
    step("rr2",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0100, 1, 1, 0);
    step("rr3",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b1000, 1, 2, 0);
    step("rr4",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0000, 1, 3, 0);
    step("rr5",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0000, 0, 0, 1);
    step("rr6",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0001, 0, 0, 0);
    step("rr7",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0010, 1, 0, 0);
    step("rr8",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0100, 1, 1, 0);
    step("rr9",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b1000, 1, 2, 0);
    step("rr10", 0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0000, 1, 3, 0);
    step("rr11", 0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0000, 0, 0, 1);
    step("idle", 0, 0, 0, 64'h0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0);

    // Dispatch priority; rr_ptr must survive dispatch grants.
    step("dp0",  0, 0, 1, 64'h1111, 4'b0100, 1, 1, 4'b0000, 0, 0, 0);
    step("dp1",  0, 0, 0, 64'h0,    4'b0100, 1, 0, 4'b0100, 1, 4, 0);
    step("dp2",  0, 0, 1, 64'h2222, 4'b1001, 1, 1, 4'b0000, 1, 2, 0);
    step("dp3",  0, 0, 0, 64'h0,    4'b1001, 1, 0, 4'b1000, 1, 4, 0);

    // Wrap 3 -> 0 -> 3, interrupted by a burst slot.
    step("wr0",  0, 0, 0, 64'h0, 4'b1001, 1, 0, 4'b0000, 1, 3, 0);
    step("wr1",  0, 0, 0, 64'h0, 4'b1001, 1, 0, 4'b0000, 0, 0, 1);
    step("wr2",  0, 0, 0, 64'h0, 4'b1001, 1, 0, 4'b0001, 0, 0, 0);
    step("wr3",  0, 0, 0, 64'h0, 4'b1001, 1, 0, 4'b1000, 1, 0, 0);
    step("wr4",  0, 0, 0, 64'h0, 4'b0000, 1, 0, 4'b0000, 1, 3, 0);

    // Backpressure: 0xA5 held three cycles, then same-cycle regrant.
    step("bp0",  0, 0, 1, 64'hA5, 4'b0010, 0, 1, 4'b0000, 0, 0, 0);
    step("bp1",  0, 0, 0, 64'h0,  4'b0010, 0, 0, 4'b0000, 1, 4, 0);
    step("bp2",  0, 0, 0, 64'h0,  4'b0010, 0, 0, 4'b0000, 1, 4, 0);
    step("bp3",  0, 0, 0, 64'h0,  4'b0010, 0, 0, 4'b0000, 1, 4, 0);
    step("bp4",  0, 0, 0, 64'h0,  4'b0010, 1, 0, 4'b0010, 1, 4, 0);
    step("bp5",  0, 0, 0, 64'h0,  4'b0000, 1, 0, 4'b0000, 1, 1, 0);

    // Three transfers, a gap, then four transfers before the slot.
    step("gp0",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0100, 0, 0, 0);
    step("gp1",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b1000, 1, 2, 0);
    step("gp2",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0001, 1, 3, 0);
    step("gp3",  0, 0, 0, 64'h0, 4'b0000, 1, 0, 4'b0000, 1, 0, 0);
    step("gp4",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0010, 0, 0, 0);
    step("gp5",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0100, 1, 1, 0);
    step("gp6",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b1000, 1, 2, 0);
    step("gp7",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0001, 1, 3, 0);
    step("gp8",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0000, 1, 0, 0);
    step("gp9",  0, 0, 0, 64'h0, 4'b0000, 1, 0, 4'b0000, 0, 0, 1);

    // Flush with a packet held: handshakes suppressed, state cleared.
    step("fl0",  0, 0, 1, 64'h77, 4'b0000, 1, 1, 4'b0000, 0, 0, 0);
    step("fl1",  0, 1, 1, 64'h88, 4'b1111, 0, 0, 4'b0000, 1, 4, 0);
    chk("fl.wb_valid",  64'(wb_valid), 64'(0));
    chk("fl.wb_src",    64'(wb_src),   64'(0));
    chk("fl.wb_packet", wb_packet,     64'(0));
    step("fl2",  0, 0, 0, 64'h0, 4'b1111, 1, 0, 4'b0001, 0, 0, 0);
    step("fl3",  0, 0, 0, 64'h0, 4'b0000, 1, 0, 4'b0000, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_wb_arbiter.md
# packet_wb_arbiter

Arbitrates the single write path into the packet SRAM between the dispatch source (DP2mem packets) and `NUM_REQ` Edge PE writeback requesters. It sits between those producers and the packet controller. It delivers one registered packet per handshake, with dispatch strict priority and round-robin among Edge PEs. After `MAX_BURST` back-to-back writes it forces a read slot, so the controller's SRAM-to-FIFO stream is never starved.

## Interface
Parameters:
- `NUM_REQ`, 4: number of Edge PE requesters (≥2).
- `PKT_W`, 64: packet width in bits.
- `MAX_BURST`, 4: maximum consecutive output transfers before a forced read slot (≥1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  iteration replay; synchronous clear, same effect as `reset`.
- `dp_valid`  in  1  dispatch packet request.
- `dp_packet`  in  PKT_W  dispatch packet.
- `dp_ready`  out  1  dispatch packet accepted this cycle.
- `req_valid`  in  NUM_REQ  Edge PE request bits.
- `req_packet`  in  NUM_REQ*PKT_W  Edge PE packets; requester i at `[i*PKT_W +: PKT_W]`.
- `req_ready`  out  NUM_REQ  one-hot accept, at most one bit set.
- `wb_valid`  out  1  registered packet available to the controller.
- `wb_packet`  out  PKT_W  registered packet.
- `wb_src`  out  $clog2(NUM_REQ+1)  source index: 0..NUM_REQ-1 is an Edge PE, NUM_REQ is dispatch.
- `wb_ready`  in  1  controller consumes `wb_*` this cycle.
- `read_slot`  out  1  one-cycle pulse; the controller may issue an SRAM read.
- `busy`  out  1  `wb_valid` OR `dp_valid` OR any `req_valid`.

## Operation
- **State machine:**
  - States are RUN and SLOT.
  - `reset` or `flush` puts the block in RUN.
  - SLOT always returns to RUN after one cycle.
- **Load enable:** `load_en = (state==RUN) && (!wb_valid || wb_ready) && !burst_hit`.
  - `burst_hit = wb_valid && wb_ready && burst_cnt==MAX_BURST-1`.
- **Winner selection** (only when `load_en`):
  - `dp_valid` wins outright.
  - Otherwise the winner is the first requester i with `req_valid[i]=1`, searching from `rr_ptr` upward with wrap modulo NUM_REQ.
- **Grant:**
  - The winner's ready (`dp_ready` or `req_ready[i]`) is asserted combinationally in the same cycle.
  - A transfer occurs when valid and ready are both high.
  - Requesters hold valid and packet stable until they see ready.
  - Grants ignore `wb_ready` except through `load_en`.
- **Output register:**
  - On a transfer, `wb_packet`/`wb_src` load next edge and `wb_valid` becomes 1.
  - If `wb_valid && wb_ready` occurs with no new transfer, `wb_valid` becomes 0.
  - `wb_packet`/`wb_src` hold while `wb_valid && !wb_ready`.
- **rr_ptr:**
  - Updates to (i+1) mod NUM_REQ only on an Edge PE transfer from requester i.
  - Unchanged on dispatch grants.
- **burst_cnt** (width $clog2(MAX_BURST+1)):
  - Increments on each `wb_valid && wb_ready`.
  - On `burst_hit`: clears to 0 and the state goes to SLOT.
  - Clears to 0 in any RUN cycle with `wb_valid==0`; a natural gap counts as a read opportunity.
- **SLOT:**
  - `read_slot=1`, `wb_valid=0`, and all readies are 0.
  - Requests wait.
- **Simultaneous events:**
  - When dispatch and Edge PEs request together, dispatch wins every cycle. Edge PEs may starve while `dp_valid` stays high; this is intended, because dispatch is finite per iteration.
- **Reset and flush:**
  - `wb_valid=0`, `wb_packet=0`, `wb_src=0`, `rr_ptr=0`, `burst_cnt=0`, state RUN.
  - `read_slot=0`, `dp_ready=0`, `req_ready=0` in the cycle `reset`/`flush` is high.
  - An in-flight `wb_*` packet is discarded.
  - `flush` dominates any handshake in the same cycle: no transfer occurs.

## Timing
- Latency: transfer in cycle t → `wb_valid` and data visible in cycle t+1.
- Throughput: one packet per cycle under continuous `wb_ready`, capped at MAX_BURST transfers.
- Burst pattern:
  - After the MAX_BURST-th consumption (cycle t), `wb_valid=0` in t+1.
  - The block is in SLOT with `read_slot=1` in t+1.
  - The next grant occurs in t+2 and its data appears in t+3.
- `read_slot` is registered (it is the SLOT state decode). Readies are combinational from the `req_valid`/`dp_valid` inputs and registered state.

## Test plan
- **Reset/flush:** Assert `reset` for 2 cycles with all requests high → all outputs 0, no readies high, `rr_ptr=0`. Repeat with `flush` while `wb_valid=1` → `wb_valid=0` on the next edge.
- **Round robin:** NUM_REQ=4, MAX_BURST=4, `req_valid=4'b1111` held, `wb_ready=1` → `wb_src` sequence is 0,1,2,3. Then `read_slot` pulses for one cycle, then 0,1,2,3 again. `req_ready` is always one-hot.
- **Dispatch priority:** `dp_valid=1` and `req_valid=4'b0100` in the same cycle → `dp_ready=1`, `wb_src=4`. Requester 2 is granted the cycle after `dp_valid` drops, and `rr_ptr` is unaffected by the dispatch grant.
- **Backpressure:** `wb_valid=1` with packet 0xA5 and `wb_ready=0` for 3 cycles → `wb_packet` stays 0xA5 and all readies are 0. When `wb_ready=1`, the next packet is granted the same cycle.
- **Gap clears burst:** 3 transfers, one idle cycle with no requests, then 4 transfers → no `read_slot` until after the 4th post-gap consumption.
- **Wrap:** Only `req_valid[3]` and `req_valid[0]` high, `rr_ptr=3` → grant 3, then 0, then 3.
